// File: rtl/ex_mem_if.sv
// ex_mem_if: EX->MEM pipeline bus. Carries the execute-stage instruction
// fields into the EX/MEM register and the registered MEM-side copies out of
// it, together with the MADD/MSUB accumulator loop back to EX.
// master: the execute side (drives ex_*, hilo_temp_i, cnt_i).
// slave : the EX/MEM stage register (drives mem_*, hilo_temp_o, cnt_o).
interface ex_mem_if #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int ALUOP_W = 8,
   parameter int CNT_W   = 2
);
   logic                  ex_valid;
   logic [REG_AW-1:0]     ex_wd;
   logic                  ex_wreg;
   logic [DATA_W-1:0]     ex_wdata;
   logic                  ex_whilo;
   logic [DATA_W-1:0]     ex_hi;
   logic [DATA_W-1:0]     ex_lo;
   logic [ALUOP_W-1:0]    ex_aluop;
   logic [DATA_W-1:0]     ex_mem_addr;
   logic [DATA_W-1:0]     ex_reg2;
   logic [DATA_W-1:0]     ex_pc;
   logic [2*DATA_W-1:0]   hilo_temp_i;
   logic [CNT_W-1:0]      cnt_i;

   logic                  mem_valid;
   logic [REG_AW-1:0]     mem_wd;
   logic                  mem_wreg;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_whilo;
   logic [DATA_W-1:0]     mem_hi;
   logic [DATA_W-1:0]     mem_lo;
   logic [ALUOP_W-1:0]    mem_aluop;
   logic [DATA_W-1:0]     mem_mem_addr;
   logic [DATA_W-1:0]     mem_reg2;
   logic [DATA_W-1:0]     mem_pc;
   logic [2*DATA_W-1:0]   hilo_temp_o;
   logic [CNT_W-1:0]      cnt_o;

   modport master (
      output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
             ex_aluop, ex_mem_addr, ex_reg2, ex_pc, hilo_temp_i, cnt_i,
      input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
             mem_aluop, mem_mem_addr, mem_reg2, mem_pc, hilo_temp_o, cnt_o
   );

   modport slave (
      input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
             ex_aluop, ex_mem_addr, ex_reg2, ex_pc, hilo_temp_i, cnt_i,
      output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
             mem_aluop, mem_mem_addr, mem_reg2, mem_pc, hilo_temp_o, cnt_o
   );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register of the MIPS core.
// Per-edge priority: rst > flush > stall_mem (hold) > stall_ex (bubble) > advance.
// A bubble clears the MEM slot but keeps the MADD/MSUB accumulator
// (hilo_temp, cnt) coming from EX so a stalled multi-cycle op survives.
// Optional build macro EX_MEM_PERF_EN adds saturating 32-bit bubble/hold
// event counters (perf_bubble, perf_hold) that clear on rst only.

// Flags the illegal stall vector (MEM stalled while EX runs); simulation only.
module ex_mem_stage_chk (
   input logic clk,
   input logic rst,
   input logic stall_ex,
   input logic stall_mem
);
   a_legal_stall_vector: assert property (
      @(posedge clk) disable iff (rst) !(stall_mem && !stall_ex)
   ) else $error("ex_mem_stage: stall_mem asserted without stall_ex");
endmodule

module ex_mem_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int ALUOP_W = 8,
   parameter int CNT_W   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        stall_ex,
   input  logic        stall_mem,
   ex_mem_if.slave     bus
`ifdef EX_MEM_PERF_EN
   ,
   output logic [31:0] perf_bubble,
   output logic [31:0] perf_hold
`endif
);

   typedef struct packed {
      logic                valid;
      logic [REG_AW-1:0]   wd;
      logic                wreg;
      logic [DATA_W-1:0]   wdata;
      logic                whilo;
      logic [DATA_W-1:0]   hi;
      logic [DATA_W-1:0]   lo;
      logic [ALUOP_W-1:0]  aluop;
      logic [DATA_W-1:0]   mem_addr;
      logic [DATA_W-1:0]   reg2;
      logic [DATA_W-1:0]   pc;
   } stage_t;

   localparam int STAGE_W = $bits(stage_t);
   localparam int HILO_W  = 2 * DATA_W;

   stage_t              stage_r;
   stage_t              stage_nxt_s;
   stage_t              ex_slot_s;
   logic [HILO_W-1:0]   hilo_r;
   logic [HILO_W-1:0]   hilo_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    cnt_nxt_s;
   logic                hold_s;
   logic                bubble_s;

   // Pack the EX slot; an invalid slot is never allowed to write GPR or HI/LO.
   always_comb begin
      ex_slot_s.valid    = bus.ex_valid;
      ex_slot_s.wd       = bus.ex_wd;
      ex_slot_s.wreg     = bus.ex_wreg & bus.ex_valid;
      ex_slot_s.wdata    = bus.ex_wdata;
      ex_slot_s.whilo    = bus.ex_whilo & bus.ex_valid;
      ex_slot_s.hi       = bus.ex_hi;
      ex_slot_s.lo       = bus.ex_lo;
      ex_slot_s.aluop    = bus.ex_aluop;
      ex_slot_s.mem_addr = bus.ex_mem_addr;
      ex_slot_s.reg2     = bus.ex_reg2;
      ex_slot_s.pc       = bus.ex_pc;
   end

   // Next-state selection following flush > hold > bubble > advance.
   always_comb begin
      stage_nxt_s = stage_r;
      hilo_nxt_s  = hilo_r;
      cnt_nxt_s   = cnt_r;
      hold_s      = 1'b0;
      bubble_s    = 1'b0;
      if (flush) begin
         stage_nxt_s = {STAGE_W{1'b0}};
         hilo_nxt_s  = {HILO_W{1'b0}};
         cnt_nxt_s   = {CNT_W{1'b0}};
      end else if (stall_mem) begin
         hold_s      = 1'b1;
      end else if (stall_ex) begin
         bubble_s    = 1'b1;
         stage_nxt_s = {STAGE_W{1'b0}};
         hilo_nxt_s  = bus.hilo_temp_i;
         cnt_nxt_s   = bus.cnt_i;
      end else begin
         stage_nxt_s = ex_slot_s;
         hilo_nxt_s  = {HILO_W{1'b0}};
         cnt_nxt_s   = {CNT_W{1'b0}};
      end
   end

   // Stage register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_r <= {STAGE_W{1'b0}};
         hilo_r  <= {HILO_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         stage_r <= stage_nxt_s;
         hilo_r  <= hilo_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   assign bus.mem_valid    = stage_r.valid;
   assign bus.mem_wd       = stage_r.wd;
   assign bus.mem_wreg     = stage_r.wreg;
   assign bus.mem_wdata    = stage_r.wdata;
   assign bus.mem_whilo    = stage_r.whilo;
   assign bus.mem_hi       = stage_r.hi;
   assign bus.mem_lo       = stage_r.lo;
   assign bus.mem_aluop    = stage_r.aluop;
   assign bus.mem_mem_addr = stage_r.mem_addr;
   assign bus.mem_reg2     = stage_r.reg2;
   assign bus.mem_pc       = stage_r.pc;
   assign bus.hilo_temp_o  = hilo_r;
   assign bus.cnt_o        = cnt_r;

`ifdef EX_MEM_PERF_EN
   logic [31:0] perf_bubble_r;
   logic [31:0] perf_hold_r;

   // Saturating bubble/hold event counters; flush does not clear them.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_bubble_r <= 32'd0;
         perf_hold_r   <= 32'd0;
      end else begin
         if (bubble_s && (perf_bubble_r != 32'hFFFF_FFFF)) begin
            perf_bubble_r <= perf_bubble_r + 32'd1;
         end
         if (hold_s && (perf_hold_r != 32'hFFFF_FFFF)) begin
            perf_hold_r <= perf_hold_r + 32'd1;
         end
      end
   end

   assign perf_bubble = perf_bubble_r;
   assign perf_hold   = perf_hold_r;
`endif

   ex_mem_stage_chk u_chk (
      .clk       (clk),
      .rst       (rst),
      .stall_ex  (stall_ex),
      .stall_mem (stall_mem)
   );

endmodule
